// File: rtl/commit_trace_queue.sv
// rtl/commit_trace_queue.sv - multi-lane commit trace FIFO with sequence tags and drop accounting
module commit_trace_queue #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int SEQW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRET-1:0]      ret_valid,
  input  logic [NRET*XLEN-1:0] ret_pc,
  input  logic [NRET*XLEN-1:0] ret_dnpc,
  input  logic [NRET*32-1:0]   ret_inst,
  input  logic [NRET-1:0]      ret_rd_we,
  input  logic [NRET*5-1:0]    ret_rd,
  input  logic [NRET*XLEN-1:0] ret_wdata,
  output logic                 ret_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEQW-1:0]      out_seq,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_dnpc,
  output logic [XLEN-1:0]      out_wdata,
  output logic [31:0]          out_inst,
  output logic                 out_rd_we,
  output logic [4:0]           out_rd,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(NRET + 1);

  logic [SEQW-1:0] mem_seq   [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_dnpc  [DEPTH];
  logic [XLEN-1:0] mem_wdata [DEPTH];
  logic [31:0]     mem_inst  [DEPTH];
  logic            mem_rd_we [DEPTH];
  logic [4:0]      mem_rd    [DEPTH];

  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, free_slots;
  logic [SEQW-1:0] seq_next;
  logic [LW-1:0]   n_ret;
  logic [LW-1:0]   lane_off [NRET];
  logic [PW-1:0]   lane_idx [NRET];
  logic            fits, do_enq, do_drop, do_pop;
  logic [16:0]     drop_sum;

  // Each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    n_ret = '0;
    for (int i = 0; i < NRET; i++) begin
      lane_off[i] = n_ret;
      lane_idx[i] = wr_ptr + PW'(lane_off[i]);
      n_ret       = n_ret + LW'(ret_valid[i]);
    end
  end

  assign free_slots = CW'(DEPTH) - count;
  assign ret_ready  = 32'(free_slots) >= 32'(NRET);
  assign fits       = 32'(n_ret) <= 32'(free_slots);
  assign do_enq     = (n_ret != '0) && !flush && fits;
  assign do_drop    = (n_ret != '0) && !flush && !fits;
  assign out_valid  = (count != '0);
  assign do_pop     = out_valid && out_ready && !flush;
  assign drop_sum   = {1'b0, drop_count} + 17'(n_ret);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq_next   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count + (do_enq ? CW'(n_ret) : CW'(0)) - CW'(do_pop);
        if (do_enq) wr_ptr <= wr_ptr + PW'(n_ret);
        if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      end
      // Dropped records still consume sequence numbers so the consumer sees the gap.
      if (do_enq || do_drop) seq_next <= seq_next + SEQW'(n_ret);
      if (do_drop) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int i = 0; i < NRET; i++) begin
        if (ret_valid[i]) begin
          mem_seq[lane_idx[i]]   <= seq_next + SEQW'(lane_off[i]);
          mem_pc[lane_idx[i]]    <= ret_pc[i*XLEN +: XLEN];
          mem_dnpc[lane_idx[i]]  <= ret_dnpc[i*XLEN +: XLEN];
          mem_wdata[lane_idx[i]] <= ret_wdata[i*XLEN +: XLEN];
          mem_inst[lane_idx[i]]  <= ret_inst[i*32 +: 32];
          mem_rd_we[lane_idx[i]] <= ret_rd_we[i];
          mem_rd[lane_idx[i]]    <= ret_rd[i*5 +: 5];
        end
      end
    end
  end

  assign out_seq   = mem_seq[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];
  assign out_dnpc  = mem_dnpc[rd_ptr];
  assign out_wdata = mem_wdata[rd_ptr];
  assign out_inst  = mem_inst[rd_ptr];
  assign out_rd_we = mem_rd_we[rd_ptr];
  assign out_rd    = mem_rd[rd_ptr];

endmodule
